// File: rtl/chan_seq_mux.sv
// Channel sequencer/mux: picks one of CHANNELS data lanes, either from a manual
// one-hot request or by auto round-robin rotation with a programmable dwell.
module chan_seq_mux #(
  parameter int BUS_WIDTH   = 1,
  parameter int CHANNELS    = 4,
  parameter int DWELL_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mode,
  input  logic [CHANNELS-1:0]           sel,
  input  logic [DWELL_WIDTH-1:0]        dwell,
  input  logic [CHANNELS*BUS_WIDTH-1:0] data_in,
  output logic [BUS_WIDTH-1:0]          out,
  output logic [CHANNELS-1:0]           cur_sel,
  output logic                          advance,
  output logic                          sel_err
);

  localparam logic [CHANNELS-1:0]    SEL_RST  = {{(CHANNELS-1){1'b0}}, 1'b1};
  localparam logic [DWELL_WIDTH-1:0] CNT_ZERO = {DWELL_WIDTH{1'b0}};
  localparam logic [DWELL_WIDTH-1:0] CNT_ONE  = {{(DWELL_WIDTH-1){1'b0}}, 1'b1};

  function automatic logic is_onehot(input logic [CHANNELS-1:0] v);
    logic seen;
    logic multi;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      multi = multi | (seen & v[i]);
      seen  = seen | v[i];
    end
    return seen & ~multi;
  endfunction

  logic [DWELL_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]    cur_sel_q, cur_sel_d;
  logic [BUS_WIDTH-1:0]   out_q, out_d;
  logic                   advance_q, advance_d;
  logic                   sel_err_q, sel_err_d;
  logic [DWELL_WIDTH-1:0] last_cnt_s;
  logic [CHANNELS-1:0]    rot_sel_s;

  // Dwell of zero behaves as one, so the terminal count is never below zero.
  assign last_cnt_s = (dwell == CNT_ZERO) ? CNT_ZERO : (dwell - CNT_ONE);
  assign rot_sel_s  = {cur_sel_q[CHANNELS-2:0], cur_sel_q[CHANNELS-1]};

  // AND-OR one-hot data mux driven by the registered selection.
  always_comb begin
    out_d = {BUS_WIDTH{1'b0}};
    for (int i = 0; i < CHANNELS; i++) begin
      out_d = out_d | (data_in[i*BUS_WIDTH +: BUS_WIDTH] & {BUS_WIDTH{cur_sel_q[i]}});
    end
  end

  // Next-state for selection, dwell counter and status pulses.
  always_comb begin
    cnt_d     = cnt_q;
    cur_sel_d = cur_sel_q;
    advance_d = 1'b0;
    sel_err_d = 1'b0;
    if (!mode) begin
      cnt_d = CNT_ZERO;
      if (is_onehot(sel)) begin
        cur_sel_d = sel;
      end else begin
        sel_err_d = 1'b1;
      end
    end else begin
      // >= rather than == so a dwell shortened below the count rotates at once.
      if (cnt_q >= last_cnt_s) begin
        cur_sel_d = rot_sel_s;
        cnt_d     = CNT_ZERO;
        advance_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
    // Recover to channel 0 should the selection register ever be corrupted.
    cur_sel_d = is_onehot(cur_sel_d) ? cur_sel_d : SEL_RST;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= CNT_ZERO;
      cur_sel_q <= SEL_RST;
      out_q     <= {BUS_WIDTH{1'b0}};
      advance_q <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      cur_sel_q <= cur_sel_d;
      out_q     <= out_d;
      advance_q <= advance_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign out     = out_q;
  assign cur_sel = cur_sel_q;
  assign advance = advance_q;
  assign sel_err = sel_err_q;

endmodule
